// File: rtl/simple_dual_port_sync_sram.sv
// simple_dual_port_sync_sram: one write port, one read port, shared clock.
// Per-byte write enables, write-first same-address bypass, registered reads
// with rd_lat (1 or 2) stages and an r_valid strobe. After reset a CLEAR
// sequence zeroes every word before traffic is accepted.
// Optional feature macro: SRAM_PARITY_EN (per-byte even parity, par_err out,
// inj_err in to corrupt stored parity).

// Per-byte-lane datapath: builds the stored lane (data plus optional parity)
// and applies the write-first bypass for the read port.
module simple_dual_port_sync_sram_lane (
  input  logic [7:0]    wr_byte,
`ifdef SRAM_PARITY_EN
  input  logic          inj,
  input  logic [8:0]    rd_lane,
  output logic [8:0]    wr_lane,
  output logic [8:0]    merged_lane,
`else
  input  logic [7:0]    rd_lane,
  output logic [7:0]    wr_lane,
  output logic [7:0]    merged_lane,
`endif
  input  logic          be,
  input  logic          bypass
);
  // Encode write lane; bypass only replaces bytes being written this cycle
  always_comb begin
`ifdef SRAM_PARITY_EN
    // Even parity bit, optionally inverted to fake a storage fault
    wr_lane = {(^wr_byte) ^ inj, wr_byte};
`else
    wr_lane = wr_byte;
`endif
    merged_lane = (bypass && be) ? wr_lane : rd_lane;
  end
endmodule

module simple_dual_port_sync_sram #(
  parameter int w      = 32,
  parameter int d      = 16,
  parameter int rd_lat = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 w_en,
  input  logic [$clog2(d)-1:0] w_ad,
  input  logic [w/8-1:0]       w_be,
  input  logic [w-1:0]         data_in,
`ifdef SRAM_PARITY_EN
  input  logic                 inj_err,
  output logic                 par_err,
`endif
  input  logic                 r_en,
  input  logic [$clog2(d)-1:0] r_ad,
  output logic [w-1:0]         data_out,
  output logic                 r_valid,
  output logic                 init_done
);
`ifdef SRAM_PARITY_EN
  localparam int PW = 1;
`else
  localparam int PW = 0;
`endif
  localparam int NB = w / 8;
  localparam int AW = $clog2(d);
  localparam int LW = 8 + PW;

  typedef logic [NB-1:0][LW-1:0] word_t;
  typedef enum logic {S_CLEAR, S_RUN} state_e;

  generate
    if ((w % 8) != 0 || w < 8 || d < 2 || (1 << AW) != d || rd_lat < 1 || rd_lat > 2) begin : g_bad_param
      $error("simple_dual_port_sync_sram: illegal parameters");
    end
  endgenerate

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          init_done_q, init_done_d;

  word_t         mem [d];

  logic          clear, run, rd_fire, bypass;
  logic          mem_we;
  logic [AW-1:0] mem_wa;
  logic [NB-1:0] mem_wbe;
  word_t         mem_wd, lane_wr, rd_raw, rd_merged;

  logic [rd_lat:1] vld_pipe_q, vld_pipe_d;
  word_t           dat_pipe_q [1:rd_lat];
  word_t           dat_pipe_d [1:rd_lat];

  // Clear FSM next state: walk the counter over every address, then run
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    case (state_q)
      S_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == AW'(d - 1)) begin
          state_d     = S_RUN;
          init_done_d = 1'b1;
          cnt_d       = '0;
        end
      end
      default: ;
    endcase
  end

  // FSM and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_CLEAR;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
    end
  end

  assign clear   = (state_q == S_CLEAR);
  assign run     = (state_q == S_RUN);
  assign rd_fire = run && r_en;
  assign bypass  = run && w_en && (w_ad == r_ad);
  assign rd_raw  = mem[r_ad];

  generate
    for (genvar k = 0; k < NB; k++) begin : g_lane
      simple_dual_port_sync_sram_lane u_lane (
        .wr_byte     (data_in[8*k +: 8]),
`ifdef SRAM_PARITY_EN
        .inj         (inj_err),
`endif
        .rd_lane     (rd_raw[k]),
        .wr_lane     (lane_wr[k]),
        .merged_lane (rd_merged[k]),
        .be          (w_be[k]),
        .bypass      (bypass)
      );
    end
  endgenerate

  // Array write port: clear sequence owns it during CLEAR (zero data and
  // zero parity, which is correct even parity for a zero byte)
  always_comb begin
    mem_we  = 1'b0;
    mem_wa  = w_ad;
    mem_wbe = w_be;
    mem_wd  = lane_wr;
    if (clear) begin
      mem_we  = 1'b1;
      mem_wa  = cnt_q;
      mem_wbe = '1;
      mem_wd  = '0;
    end else if (w_en) begin
      mem_we  = 1'b1;
    end
  end

  // Storage array; deliberately no reset so contents are never touched asynchronously
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int k = 0; k < NB; k++) begin
        if (mem_wbe[k]) mem[mem_wa][k] <= mem_wd[k];
      end
    end
  end

  // Read pipeline next state: each stage loads only when a read moves into it,
  // so the output stage holds its last result between reads
  always_comb begin
    vld_pipe_d    = '0;
    dat_pipe_d    = dat_pipe_q;
    vld_pipe_d[1] = rd_fire;
    if (rd_fire) dat_pipe_d[1] = rd_merged;
    for (int k = 2; k <= rd_lat; k++) begin
      vld_pipe_d[k] = vld_pipe_q[k-1];
      if (vld_pipe_q[k-1]) dat_pipe_d[k] = dat_pipe_q[k-1];
    end
  end

  // Read pipeline registers, flushed on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe_q <= '0;
      for (int k = 1; k <= rd_lat; k++) dat_pipe_q[k] <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      for (int k = 1; k <= rd_lat; k++) dat_pipe_q[k] <= dat_pipe_d[k];
    end
  end

  // Output unpacking (and parity check on the final stage)
  always_comb begin
    for (int k = 0; k < NB; k++) data_out[8*k +: 8] = dat_pipe_q[rd_lat][k][7:0];
    r_valid   = vld_pipe_q[rd_lat];
    init_done = init_done_q;
`ifdef SRAM_PARITY_EN
    par_err = 1'b0;
    for (int k = 0; k < NB; k++) begin
      if (^dat_pipe_q[rd_lat][k]) par_err = vld_pipe_q[rd_lat];
    end
`endif
  end
endmodule

// File: tb/tb_simple_dual_port_sync_sram.sv
// Directed bench for simple_dual_port_sync_sram: a rd_lat=1 and a rd_lat=2
// instance share all inputs.
module tb_simple_dual_port_sync_sram;
  logic        clk, rst;
  logic        w_en, r_en;
  logic [3:0]  w_ad, r_ad, w_be;
  logic [31:0] data_in;
  logic [31:0] do1, do2;
  logic        rv1, rv2, id1, id2;
`ifdef SRAM_PARITY_EN
  logic        inj_err, pe1, pe2;
`endif
  int errors = 0;
  int checks = 0;

  simple_dual_port_sync_sram #(.w(32), .d(16), .rd_lat(1)) u_dut (
    .clk(clk), .rst(rst), .w_en(w_en), .w_ad(w_ad), .w_be(w_be), .data_in(data_in),
`ifdef SRAM_PARITY_EN
    .inj_err(inj_err), .par_err(pe1),
`endif
    .r_en(r_en), .r_ad(r_ad), .data_out(do1), .r_valid(rv1), .init_done(id1));

  simple_dual_port_sync_sram #(.w(32), .d(16), .rd_lat(2)) u_dut2 (
    .clk(clk), .rst(rst), .w_en(w_en), .w_ad(w_ad), .w_be(w_be), .data_in(data_in),
`ifdef SRAM_PARITY_EN
    .inj_err(inj_err), .par_err(pe2),
`endif
    .r_en(r_en), .r_ad(r_ad), .data_out(do2), .r_valid(rv2), .init_done(id2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [31:0] v, input logic [3:0] be);
    w_en = 1'b1; w_ad = a; data_in = v; w_be = be;
    step();
    w_en = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] a);
    r_en = 1'b1; r_ad = a;
    step();
    r_en = 1'b0;
  endtask

  task automatic test_reset();
    int cyc;
    rst = 1'b1;
    step(); step();
    checks++; if (do1 !== 32'h0) begin errors++; $display("FAIL reset_data_out got %h want 00000000", do1); end
    checks++; if (rv1 !== 1'b0) begin errors++; $display("FAIL reset_r_valid got %b want 0", rv1); end
    checks++; if (id1 !== 1'b0 || id2 !== 1'b0) begin errors++; $display("FAIL reset_init_done got %b/%b want 0/0", id1, id2); end
    rst = 1'b0;
    cyc = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (id1 === 1'b1) begin cyc = i; break; end
    end
    checks++; if (cyc != 16) begin errors++; $display("FAIL clear_length got %0d cycles want 16", cyc); end
    checks++; if (id2 !== 1'b1) begin errors++; $display("FAIL clear_length_lat2 init_done got %b want 1", id2); end
    for (int a = 0; a < 16; a++) begin
      do_read(4'(a));
      checks++; if (rv1 !== 1'b1) begin errors++; $display("FAIL clear_read_valid addr %0d got %b want 1", a, rv1); end
      checks++; if (do1 !== 32'h0) begin errors++; $display("FAIL clear_read_data addr %0d got %h want 00000000", a, do1); end
`ifdef SRAM_PARITY_EN
      checks++; if (pe1 !== 1'b0) begin errors++; $display("FAIL clear_parity addr %0d got %b want 0", a, pe1); end
`endif
    end
    step();
    checks++; if (rv1 !== 1'b0) begin errors++; $display("FAIL idle_r_valid got %b want 0", rv1); end
  endtask

  task automatic test_byte_merge();
    do_write(4'd3, 32'hAABBCCDD, 4'b1111);
    do_write(4'd3, 32'h11223344, 4'b0101);
    do_read(4'd3);
    checks++; if (rv1 !== 1'b1 || do1 !== 32'hAA22CC44) begin errors++; $display("FAIL byte_merge got %h v=%b want AA22CC44 v=1", do1, rv1); end
    do_write(4'd3, 32'hFFFFFFFF, 4'b0000);
    do_read(4'd3);
    checks++; if (do1 !== 32'hAA22CC44) begin errors++; $display("FAIL be_zero_noop got %h want AA22CC44", do1); end
    step();
    checks++; if (rv1 !== 1'b0 || do1 !== 32'hAA22CC44) begin errors++; $display("FAIL data_hold got %h v=%b want AA22CC44 v=0", do1, rv1); end
  endtask

  task automatic test_read_during_write();
    do_write(4'd5, 32'h12345678, 4'b1111);
    w_en = 1'b1; w_ad = 4'd5; data_in = 32'hDEADBEEF; w_be = 4'b0011;
    r_en = 1'b1; r_ad = 4'd5;
    step();
    w_en = 1'b0; r_en = 1'b0;
    checks++; if (rv1 !== 1'b1 || do1 !== 32'h1234BEEF) begin errors++; $display("FAIL rdw_bypass got %h v=%b want 1234BEEF v=1", do1, rv1); end
    do_read(4'd5);
    checks++; if (do1 !== 32'h1234BEEF) begin errors++; $display("FAIL rdw_stored got %h want 1234BEEF", do1); end
    w_en = 1'b1; w_ad = 4'd6; data_in = 32'h00000055; w_be = 4'b1111;
    r_en = 1'b1; r_ad = 4'd3;
    step();
    w_en = 1'b0; r_en = 1'b0;
    checks++; if (do1 !== 32'hAA22CC44) begin errors++; $display("FAIL rw_diff_addr got %h want AA22CC44", do1); end
    do_read(4'd6);
    checks++; if (do1 !== 32'h00000055) begin errors++; $display("FAIL rw_diff_write got %h want 00000055", do1); end
  endtask

  task automatic test_latency();
    for (int a = 0; a < 4; a++) do_write(4'(a), 32'(a), 4'b1111);
    for (int i = 0; i < 6; i++) begin
      r_en = (i < 4); r_ad = 4'(i);
      step();
      checks++; if (rv2 !== ((i >= 1 && i <= 4) ? 1'b1 : 1'b0)) begin errors++; $display("FAIL lat2_valid cycle %0d got %b", i, rv2); end
      if (i >= 1) begin
        checks++; if (do2 !== 32'(i >= 5 ? 3 : i - 1)) begin errors++; $display("FAIL lat2_data cycle %0d got %h want %h", i, do2, 32'(i >= 5 ? 3 : i - 1)); end
      end
      checks++; if (rv1 !== ((i <= 3) ? 1'b1 : 1'b0)) begin errors++; $display("FAIL lat1_valid cycle %0d got %b", i, rv1); end
      if (i <= 3) begin
        checks++; if (do1 !== 32'(i)) begin errors++; $display("FAIL lat1_data cycle %0d got %h want %h", i, do1, 32'(i)); end
      end
    end
    r_en = 1'b0;
  endtask

  task automatic test_mid_reset();
    int  cyc;
    logic bad;
    do_write(4'd7, 32'hCAFEF00D, 4'b1111);
    do_read(4'd7);
    checks++; if (do1 !== 32'hCAFEF00D) begin errors++; $display("FAIL pre_reset_read got %h want CAFEF00D", do1); end
    rst = 1'b1; step(); rst = 1'b0;
    repeat (5) step();
    rst = 1'b1; step();
    checks++; if (id1 !== 1'b0 || rv1 !== 1'b0 || do1 !== 32'h0) begin errors++; $display("FAIL mid_reset_state got id=%b v=%b d=%h want 0/0/0", id1, rv1, do1); end
    rst = 1'b0;
    w_en = 1'b1; w_ad = 4'd7; data_in = 32'hFFFFFFFF; w_be = 4'b1111;
    r_en = 1'b1; r_ad = 4'd7;
    cyc = 0; bad = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (rv1 !== 1'b0 || rv2 !== 1'b0) bad = 1'b1;
      if (id1 === 1'b1) begin cyc = i; break; end
    end
    w_en = 1'b0; r_en = 1'b0;
    checks++; if (cyc != 16) begin errors++; $display("FAIL reclear_length got %0d cycles want 16", cyc); end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL clear_r_valid got 1 want 0"); end
    do_read(4'd7);
    checks++; if (do1 !== 32'h0) begin errors++; $display("FAIL reclear_addr7 got %h want 00000000", do1); end
  endtask

`ifdef SRAM_PARITY_EN
  task automatic test_parity();
    inj_err = 1'b1;
    do_write(4'd2, 32'h0F0F0F0F, 4'b1111);
    inj_err = 1'b0;
    do_read(4'd2);
    checks++; if (pe1 !== 1'b1 || do1 !== 32'h0F0F0F0F) begin errors++; $display("FAIL parity_inject got pe=%b d=%h want 1 0F0F0F0F", pe1, do1); end
    do_write(4'd2, 32'h0F0F0F0F, 4'b1111);
    do_read(4'd2);
    checks++; if (pe1 !== 1'b0) begin errors++; $display("FAIL parity_clean got %b want 0", pe1); end
    inj_err = 1'b1;
    w_en = 1'b1; w_ad = 4'd2; data_in = 32'h01010101; w_be = 4'b0001;
    r_en = 1'b1; r_ad = 4'd2;
    step();
    w_en = 1'b0; r_en = 1'b0; inj_err = 1'b0;
    checks++; if (pe1 !== 1'b1 || do1 !== 32'h0F0F0F01) begin errors++; $display("FAIL parity_bypass got pe=%b d=%h want 1 0F0F0F01", pe1, do1); end
    step();
    checks++; if (pe1 !== 1'b0) begin errors++; $display("FAIL parity_idle got %b want 0", pe1); end
  endtask
`endif

  initial begin
    rst = 1'b0; w_en = 1'b0; r_en = 1'b0; w_ad = '0; r_ad = '0; w_be = '0; data_in = '0;
`ifdef SRAM_PARITY_EN
    inj_err = 1'b0;
`endif
    #2;
    test_reset();
    test_byte_merge();
    test_read_during_write();
    test_latency();
    test_mid_reset();
`ifdef SRAM_PARITY_EN
    test_parity();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
